seq_signed_divider: RTL

- Sequential signed divider; the inverse operation of the team's combinational 4x4 Booth multiplier (booth_main).
- Takes an 8-bit signed product-width dividend and a 4-bit signed divisor, and returns a signed quotient and remainder.
- Uses restoring division on magnitudes, one quotient bit per clock, with a start/busy/done handshake.
- Feeds the team's multiply/divide round-trip checks.

---
 rtl/div_pkg.sv | 18 +
 rtl/seq_signed_divider_if.sv | 27 ++
 rtl/div_restore_step.sv | 29 ++
 rtl/seq_signed_divider.sv | 120 ++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(DW);

  // Quotient returned for a zero divisor (-1 in two's complement).
  localparam logic [DW-1:0] DBZ_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_signed_divider_if.sv
// Handshake and operand/result bundle for seq_signed_divider.
interface seq_signed_divider_if #(
  parameter int unsigned WIDTH = div_pkg::WIDTH
);

  logic                   start;
  logic [2*WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]       divisor;
  logic                   ready;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]       remainder;
  logic                   div_by_zero;
  logic                   overflow;

  modport master (
    output start, dividend, divisor,
    input  ready, busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/div_restore_step.sv
// One combinational restoring-division step on magnitudes.
module div_restore_step #(
  parameter int unsigned WIDTH = div_pkg::WIDTH
) (
  input  logic [WIDTH:0]     rem,
  input  logic [2*WIDTH-1:0] work,
  input  logic [WIDTH-1:0]   dvs,
  output logic [WIDTH:0]     rem_nxt,
  output logic [2*WIDTH-1:0] work_nxt
);

  localparam int unsigned QW = 2 * WIDTH;

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] diff;

  // Shift {rem, work} left, trial-subtract the divisor, keep or restore.
  always_comb begin
    rem_sh   = {rem, work[QW-1]};
    diff     = rem_sh - (WIDTH+2)'(dvs);
    rem_nxt  = rem_sh[WIDTH:0];
    work_nxt = {work[QW-2:0], 1'b0};
    if (!diff[WIDTH+1]) begin
      rem_nxt  = diff[WIDTH:0];
      work_nxt = {work[QW-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: restoring division on magnitudes, one bit per clock.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = div_pkg::WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  seq_signed_divider_if.slave bus
);

  localparam int unsigned QW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(QW);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [WIDTH:0]    rem;
  logic [QW-1:0]     work;
  logic [WIDTH-1:0]  dvs_mag;
  logic              neg_dd;
  logic              neg_dv;
  logic              dbz;

  logic [WIDTH:0]    rem_nxt;
  logic [QW-1:0]     work_nxt;
  logic [QW-1:0]     dd_mag_c;
  logic [WIDTH-1:0]  dv_mag_c;
  logic              dv_zero_c;
  logic              neg_q_c;

  // Operand magnitudes; -2^(n-1) maps to 2^(n-1) as an unsigned value.
  always_comb begin
    dd_mag_c  = bus.dividend[QW-1] ? (~bus.dividend + QW'(1)) : bus.dividend;
    dv_mag_c  = bus.divisor[WIDTH-1] ? (~bus.divisor + WIDTH'(1)) : bus.divisor;
    dv_zero_c = (bus.divisor == '0);
    neg_q_c   = neg_dd ^ neg_dv;
  end

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem),
    .work     (work),
    .dvs      (dvs_mag),
    .rem_nxt  (rem_nxt),
    .work_nxt (work_nxt)
  );

  // Control FSM, bit counter, working registers and registered outputs.
  // A zero divisor skips CALC and lets SIGN load the fixed result, so done
  // arrives two cycles after acceptance like a zero-length division.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      rem             <= '0;
      work            <= '0;
      dvs_mag         <= '0;
      neg_dd          <= 1'b0;
      neg_dv          <= 1'b0;
      dbz             <= 1'b0;
      bus.ready       <= 1'b1;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg_dd          <= bus.dividend[QW-1];
            neg_dv          <= bus.divisor[WIDTH-1];
            work            <= dd_mag_c;
            rem             <= '0;
            dvs_mag         <= dv_mag_c;
            cnt             <= CW'(QW - 1);
            dbz             <= dv_zero_c;
            bus.ready       <= 1'b0;
            bus.busy        <= 1'b1;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
            state           <= dv_zero_c ? SIGN : CALC;
          end
        end
        CALC: begin
          rem  <= rem_nxt;
          work <= work_nxt;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          if (dbz) begin
            bus.quotient    <= '1;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b1;
          end else begin
            bus.quotient  <= neg_q_c ? (~work + QW'(1)) : work;
            bus.remainder <= neg_dd ? (~rem[WIDTH-1:0] + WIDTH'(1)) : rem[WIDTH-1:0];
            // Only -2^(QW-1) / -1 yields a positive magnitude with the MSB set.
            bus.overflow  <= ~neg_q_c & work[QW-1];
          end
          bus.done <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          bus.done  <= 1'b0;
          bus.busy  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
